// File: rtl/alu_out_serializer.sv
// Captures ALU results into a small FIFO and serializes each word as two bytes
// (low byte first) over a valid/ready byte stream.
module alu_out_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  OUT_VALID,
  input  logic                  CLR_OVF,
  output logic [7:0]            BYTE_OUT,
  output logic                  BYTE_VALID,
  input  logic                  BYTE_READY,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVERFLOW,
  output logic                  BUSY
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic [15:0]       r_hold;
  logic              r_ovf;
  logic [15:0]       w_word;
  logic              w_pop, w_push, w_drop, w_full, w_empty;
  logic [7:0]        w_byte;
  logic              w_bvalid;

  // Only the low 16 bits are ever serialized; narrower results are zero-extended.
  generate
    if (DATA_WIDTH >= 16) begin : g_wide
      assign w_word = ALU_OUT[15:0];
    end else begin : g_narrow
      assign w_word = {{(16-DATA_WIDTH){1'b0}}, ALU_OUT};
    end
  endgenerate

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = OUT_VALID && (!w_full || w_pop);
  assign w_drop  = OUT_VALID && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_bvalid    = 1'b0;
    w_byte      = 8'h00;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND_LO;
        end
      end
      SEND_LO: begin
        w_bvalid = 1'b1;
        w_byte   = r_hold[7:0];
        if (BYTE_READY) w_state_nxt = SEND_HI;
      end
      SEND_HI: begin
        w_bvalid = 1'b1;
        w_byte   = r_hold[15:8];
        if (BYTE_READY) begin
          // Chain straight into the next word so there is no bubble.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = SEND_LO;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_hold <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (CLR_OVF) r_ovf <= 1'b0;
  end

  assign BYTE_OUT   = w_byte;
  assign BYTE_VALID = w_bvalid;
  assign FULL       = w_full;
  assign EMPTY      = w_empty;
  assign OVERFLOW   = r_ovf;
  assign BUSY       = (r_state != IDLE);
endmodule

// File: tb/tb_alu_out_serializer.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor checks
// every accepted byte and the hold-stable rule under backpressure.
module tb_alu_out_serializer;
  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID, CLR_OVF, BYTE_READY;
  logic [7:0]  BYTE_OUT;
  logic        BYTE_VALID, FULL, EMPTY, OVERFLOW, BUSY;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  alu_out_serializer #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .CLR_OVF(CLR_OVF), .BYTE_OUT(BYTE_OUT), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .FULL(FULL), .EMPTY(EMPTY),
    .OVERFLOW(OVERFLOW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, BYTE_VALID}, 32'd1);
        chk("stall_byte", {24'd0, BYTE_OUT}, {24'd0, prev_byte});
      end
      if (BYTE_VALID && BYTE_READY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, BYTE_OUT}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_byte", {24'd0, BYTE_OUT}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = BYTE_VALID && !BYTE_READY;
      prev_byte  = BYTE_OUT;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_word(input logic [15:0] w, input bit expect_out);
    ALU_OUT   = w;
    OUT_VALID = 1'b1;
    if (expect_out) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
    tick();
    OUT_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !BUSY && EMPTY) && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, (n < 200)}, 32'd1);
  endtask

  initial begin
    RST = 1'b0; ALU_OUT = '0; OUT_VALID = 1'b0; CLR_OVF = 1'b0; BYTE_READY = 1'b0;
    #12;
    chk("rst_bvalid", {31'd0, BYTE_VALID}, 32'd0);
    chk("rst_bout", {24'd0, BYTE_OUT}, 32'd0);
    chk("rst_empty", {31'd0, EMPTY}, 32'd1);
    chk("rst_full", {31'd0, FULL}, 32'd0);
    chk("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    #5 RST = 1'b1;
    tick();

    // single word, latency and back-to-back bytes
    BYTE_READY = 1'b1;
    drive_word(16'h0186, 1'b1);
    chk("lat_not_yet", {31'd0, BYTE_VALID}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, BYTE_VALID}, 32'd1);
    chk("lat_lo", {24'd0, BYTE_OUT}, 32'h86);
    tick();
    chk("hi_byte", {24'd0, BYTE_OUT}, 32'h01);
    tick();
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
    chk("idle_empty", {31'd0, EMPTY}, 32'd1);
    chk("idle_bout", {24'd0, BYTE_OUT}, 32'd0);

    // backpressure
    BYTE_READY = 1'b0;
    drive_word(16'h0186, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_lo", {23'd0, BYTE_VALID, BYTE_OUT}, 32'h186);
    end
    BYTE_READY = 1'b1;
    wait_drain("bp_drain");

    // overflow: word 6 dropped
    BYTE_READY = 1'b0;
    for (int i = 1; i <= 6; i++) drive_word(16'(i), i <= 5);
    chk("ovf_full", {31'd0, FULL}, 32'd1);
    chk("ovf_set", {31'd0, OVERFLOW}, 32'd1);
    chk("ovf_hold", {24'd0, BYTE_OUT}, 32'h01);
    BYTE_READY = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", {31'd0, OVERFLOW}, 32'd1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    chk("ovf_clr", {31'd0, OVERFLOW}, 32'd0);

    // push/pop collision on a full FIFO at the SEND_HI accept edge
    BYTE_READY = 1'b0;
    drive_word(16'h0011, 1'b1);
    drive_word(16'h0022, 1'b1);
    drive_word(16'h0033, 1'b1);
    drive_word(16'h0044, 1'b1);
    drive_word(16'h0055, 1'b1);
    chk("col_full_pre", {31'd0, FULL}, 32'd1);
    BYTE_READY = 1'b1;
    tick();
    chk("col_in_hi", {24'd0, BYTE_OUT}, 32'h00);
    drive_word(16'h00AA, 1'b1);
    chk("col_full", {31'd0, FULL}, 32'd1);
    chk("col_ovf", {31'd0, OVERFLOW}, 32'd0);
    wait_drain("col_drain");

    // reset in SEND_HI with two words queued
    BYTE_READY = 1'b0;
    drive_word(16'h0101, 1'b1);
    drive_word(16'h0202, 1'b1);
    drive_word(16'h0303, 1'b1);
    BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    chk("mid_busy", {31'd0, BUSY}, 32'd1);
    chk("mid_hi", {24'd0, BYTE_OUT}, 32'h01);
    #1 RST = 1'b0;
    #1;
    chk("arst_bvalid", {31'd0, BYTE_VALID}, 32'd0);
    chk("arst_empty", {31'd0, EMPTY}, 32'd1);
    chk("arst_busy", {31'd0, BUSY}, 32'd0);
    exp_q.delete();
    tick();
    #3 RST = 1'b1;
    BYTE_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_quiet", {30'd0, BYTE_VALID, EMPTY}, 32'd1);
    end

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_out_serializer.md
ALU_OUT_SERIALIZER -- requirements
Module: alu_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of the captured ALU result (an even number).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of result FIFO entries (a power of 2, at least 2).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ALU_OUT, input, DATA_WIDTH bits: the result word from the upstream ALU.
REQ-006 The block SHALL have port OUT_VALID, input, 1 bit: ALU_OUT is valid this cycle; each high cycle is one result.
REQ-007 The block SHALL have port CLR_OVF, input, 1 bit: synchronous clear of OVERFLOW.
REQ-008 The block SHALL have port BYTE_OUT, output, 8 bits: the serialized result byte.
REQ-009 The block SHALL have port BYTE_VALID, output, 1 bit: BYTE_OUT holds a valid byte.
REQ-010 The block SHALL have port BYTE_READY, input, 1 bit: the consumer accepts the byte.
REQ-011 The block SHALL have port FULL, output, 1 bit: the FIFO holds DEPTH entries.
REQ-012 The block SHALL have port EMPTY, output, 1 bit: the FIFO holds 0 entries.
REQ-013 The block SHALL have port OVERFLOW, output, 1 bit: sticky flag, set when a result was dropped.
REQ-014 The block SHALL have port BUSY, output, 1 bit: the serializer state is not IDLE.

Function
REQ-015 The block SHALL capture ALU_OUT into the FIFO tail on each rising edge where OUT_VALID=1 and (count<DEPTH or a pop occurs on the same edge).
REQ-016 On a simultaneous push and pop, the block SHALL leave count unchanged and keep the data ordering intact.
REQ-017 On a push attempt with count==DEPTH and no same-edge pop, the block SHALL drop the word, leave the FIFO unchanged, and set OVERFLOW on that edge.
REQ-018 OVERFLOW SHALL clear only on reset or on an edge with CLR_OVF=1; if a drop occurs on the same edge as CLR_OVF=1, the set SHALL win.
REQ-019 The read and write pointers SHALL wrap modulo DEPTH, and count SHALL range from 0 to DEPTH.
REQ-020 FULL SHALL be (count==DEPTH) and EMPTY SHALL be (count==0), both registered-state derived, with no combinational path from OUT_VALID.
REQ-021 The serializer FSM SHALL have the states IDLE, SEND_LO and SEND_HI.
REQ-022 In IDLE with count>0, the FSM SHALL pop the head into a DATA_WIDTH holding register and go to SEND_LO on the same edge.
REQ-023 In SEND_LO, the block SHALL drive BYTE_VALID=1 and BYTE_OUT=hold[7:0]; on an edge with BYTE_READY=1 it SHALL go to SEND_HI.
REQ-024 In SEND_HI, the block SHALL drive BYTE_VALID=1 and BYTE_OUT=hold[15:8]; on an edge with BYTE_READY=1 it SHALL pop the next word and go to SEND_LO if count>0, or else go to IDLE.
REQ-025 For DATA_WIDTH>16, the block SHALL use only bits [15:0]; upper bits are discarded.
REQ-026 BYTE_VALID SHALL be 0 in IDLE, and BYTE_OUT SHALL hold 8'h00 in IDLE.
REQ-027 While BYTE_VALID=1 and BYTE_READY=0, BYTE_OUT SHALL hold stable and BYTE_VALID SHALL stay high.
REQ-028 Latency: with a result sampled at edge k into an empty, idle block, BYTE_VALID SHALL rise after edge k+1.
REQ-029 Throughput: with BYTE_READY=1 held, the block SHALL emit one byte per cycle, with no bubble between consecutive words.
REQ-030 BUSY SHALL be 1 in SEND_LO and SEND_HI.
REQ-031 The holding register SHALL not be counted in count.

Reset
REQ-032 On RST=0, the block SHALL immediately and asynchronously enter IDLE and clear pointers, count and the holding register.
REQ-033 During reset, the outputs SHALL be: BYTE_VALID=0, BYTE_OUT=8'h00, EMPTY=1, FULL=0, OVERFLOW=0, BUSY=0.
REQ-034 On reset, a byte in flight and all stored words SHALL be lost, and the block SHALL not emit partial words after reset releases.
REQ-035 After reset releases, the first rising edge SHALL operate normally.

Verification
REQ-036 Reset check: assert RST=0 for 1.5 cycles -> BYTE_VALID=0, EMPTY=1, FULL=0, OVERFLOW=0, BUSY=0.
REQ-037 Single word: ALU_OUT=16'd390 (0x0186) with OUT_VALID for 1 cycle and BYTE_READY=1 -> BYTE_VALID rises after edge k+1; bytes 0x86 then 0x01 on consecutive cycles, then IDLE and EMPTY=1.
REQ-038 Backpressure: as REQ-037 but BYTE_READY=0 for 5 cycles -> BYTE_OUT=0x86 stable for all 5; after READY=1, bytes 0x86 then 0x01.
REQ-039 Overflow: BYTE_READY=0, push 0x0001..0x0006 on back-to-back cycles -> 0x0001 held, 0x0002-0x0005 in FIFO, FULL=1, 0x0006 dropped, OVERFLOW=1. Then READY=1 -> 01 00 02 00 03 00 04 00 05 00, no 06; OVERFLOW stays 1 until CLR_OVF=1 pulse.
REQ-040 Push/pop collision: FIFO full, OUT_VALID=1 with ALU_OUT=0x00AA on the SEND_HI accept edge -> word accepted, FULL stays 1, OVERFLOW stays 0, 0xAA 0x00 emitted last.
REQ-041 Reset mid-operation: RST=0 while in SEND_HI with 2 words queued -> BYTE_VALID=0 without waiting for a clock edge; after release, EMPTY=1 and no bytes are emitted.
